// File: rtl/des_round_sequencer.sv
// Iterative DES controller: IP/FP wrap, key schedule and one Feistel round per cycle.
// Ports: clk, rst_n (async, active low), in_valid/in_ready/in_data/in_key/in_decrypt,
//   out_valid/out_ready/out_data, busy, round_idx.
// Option: define DES_SEQ_UNROLL2_EN for two chained rounds per cycle (ROUNDS must be even).
module des_round_sequencer #(
    parameter int ROUNDS      = 16,
    parameter int ROUND_CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_data,
    input  logic [63:0]            in_key,
    input  logic                   in_decrypt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_data,
    output logic                   busy,
    output logic [ROUND_CNT_W-1:0] round_idx
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

`ifdef DES_SEQ_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [ROUND_CNT_W-1:0] STEP_W   = ROUND_CNT_W'(STEP);
    localparam logic [ROUND_CNT_W-1:0] LAST_IDX = ROUND_CNT_W'(ROUNDS - STEP);

    // Bit i set where schedule step i moves by one position (else two).
    localparam logic [15:0] S1_MASK = 16'h8103;
    localparam logic [15:0] R1_MASK = 16'hC081;

    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
        12,13,14,15,16,17, 16,17,18,19,20,21,
        20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
        10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
        14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10,
        23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48,
        44,49,39,56,34,53, 46,42,50,36,29,32};
    // One word per S-box row, 16 nibbles with column 0 leftmost.
    localparam logic [63:0] SBOX [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
        64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
        64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
        64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
        64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
        64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
        64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
        64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
        64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[6'(63-i)] = x[6'(64-IP_T[i])];
        return o;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[6'(63-i)] = x[6'(64-FP_T[i])];
        return o;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[6'(55-i)] = k[6'(64-PC1_T[i])];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[6'(47-i)] = cd[6'(56-PC2_T[i])];
        return o;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  six;
        logic [63:0] w;
        for (int i = 0; i < 48; i++) x[6'(47-i)] = r[5'(32-E_T[i])];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47-6*b) -: 6];
            w   = SBOX[5'(4*b + 2*int'(six[5]) + int'(six[0]))];
            s[5'(31-4*b) -: 4] = w[6'(63 - 4*int'(six[4:1])) -: 4];
        end
        for (int i = 0; i < 32; i++) o[5'(31-i)] = s[5'(32-P_T[i])];
        return o;
    endfunction

    state_t                   state_q;
    logic [31:0]              l_q, r_q, l_d, r_d, l1, r1;
    logic [27:0]              c_q, d_q, c_d, d_d, c1, d1;
    logic [47:0]              k1;
    logic [ROUND_CNT_W-1:0]   rnd_q;
    logic                     dec_q;
    logic                     out_valid_q;
    logic [63:0]              out_data_q;
    logic                     accept;
`ifdef DES_SEQ_UNROLL2_EN
    logic [27:0]              c2, d2;
    logic [47:0]              k2;
    logic [ROUND_CNT_W-1:0]   rnd_n;
`endif

    // Encrypt rotates before deriving the key; decrypt derives then undoes.
    always_comb begin
        if (dec_q) begin
            k1 = pc2({c_q, d_q});
            c1 = rotr(c_q, R1_MASK[rnd_q[3:0]]);
            d1 = rotr(d_q, R1_MASK[rnd_q[3:0]]);
        end else begin
            c1 = rotl(c_q, S1_MASK[rnd_q[3:0]]);
            d1 = rotl(d_q, S1_MASK[rnd_q[3:0]]);
            k1 = pc2({c1, d1});
        end
        l1 = r_q;
        r1 = l_q ^ feistel(r_q, k1);
`ifdef DES_SEQ_UNROLL2_EN
        rnd_n = rnd_q + 1'b1;
        if (dec_q) begin
            k2 = pc2({c1, d1});
            c2 = rotr(c1, R1_MASK[rnd_n[3:0]]);
            d2 = rotr(d1, R1_MASK[rnd_n[3:0]]);
        end else begin
            c2 = rotl(c1, S1_MASK[rnd_n[3:0]]);
            d2 = rotl(d1, S1_MASK[rnd_n[3:0]]);
            k2 = pc2({c2, d2});
        end
        l_d = r1;
        r_d = l1 ^ feistel(r1, k2);
        c_d = c2;
        d_d = d2;
`else
        l_d = l1;
        r_d = r1;
        c_d = c1;
        d_d = d1;
`endif
    end

    // in_ready is forced low while reset is held.
    assign in_ready  = rst_n & ((state_q == IDLE) |
                                ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == RUN);
    assign round_idx = (state_q == RUN) ? rnd_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            rnd_q       <= '0;
            dec_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        {l_q, r_q} <= ip(in_data);
                        {c_q, d_q} <= pc1(in_key);
                        dec_q      <= in_decrypt;
                        rnd_q      <= '0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    c_q   <= c_d;
                    d_q   <= d_d;
                    rnd_q <= rnd_q + STEP_W;
                    if (rnd_q == LAST_IDX) begin
                        // Output undoes the last half-swap.
                        out_data_q  <= fp({r_d, l_d});
                        out_valid_q <= 1'b1;
                        rnd_q       <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        if (in_valid) begin
                            {l_q, r_q} <= ip(in_data);
                            {c_q, d_q} <= pc1(in_key);
                            dec_q      <= in_decrypt;
                            rnd_q      <= '0;
                            state_q    <= RUN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer: known DES vectors, latency,
// back-to-back accept, backpressure and mid-block reset.
module tb_des_round_sequencer;

`ifdef DES_SEQ_UNROLL2_EN
    localparam int LAT     = 8;
    localparam int RST_IDX = 6;
`else
    localparam int LAT     = 16;
    localparam int RST_IDX = 7;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic [4:0]  round_idx;

    int checks = 0;
    int errors = 0;
    int n;

    des_round_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic issue(input logic [63:0] d, input logic [63:0] k,
                         input logic dec);
        in_valid   = 1'b1;
        in_data    = d;
        in_key     = k;
        in_decrypt = dec;
        step();
        in_valid   = 1'b0;
        in_data    = '0;
        in_key     = '0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_key     = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_round_idx", 64'(round_idx), 64'd0);

        // Vector 1 encrypt
        issue(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
        check("v1_busy", 64'(busy), 64'd1);
        check("v1_in_ready_run", 64'(in_ready), 64'd0);
        check("v1_idx0", 64'(round_idx), 64'd0);
        step();
        check("v1_idx1", 64'(round_idx), 64'(LAT == 8 ? 2 : 1));
        wait_out(n);
        check("v1_latency", 64'(n + 1), 64'(LAT));
        check("v1_data", out_data, 64'h85E813540F0AB405);
        check("v1_busy_done", 64'(busy), 64'd0);
        check("v1_idx_done", 64'(round_idx), 64'd0);

        // Backpressure: hold for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_data", out_data, 64'h85E813540F0AB405);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        drain();

        // Vector 2 decrypt
        issue(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1);
        wait_out(n);
        check("v2_latency", 64'(n), 64'(LAT));
        check("v2_data", out_data, 64'h0123456789ABCDEF);
        drain();

        // Vector 3 then back-to-back decrypt
        issue(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0);
        wait_out(n);
        check("v3_latency", 64'(n), 64'(LAT));
        check("v3_data", out_data, 64'h0000000000000000);
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        issue(64'h0000000000000000, 64'h0E329232EA6D0D73, 1'b1);
        out_ready = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_valid_low", 64'(out_valid), 64'd0);
        wait_out(n);
        check("b2b_latency", 64'(n), 64'(LAT));
        check("b2b_data", out_data, 64'h8787878787878787);
        drain();

        // Reset in the middle of a block
        issue(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
        n = 0;
        while (round_idx != 5'(RST_IDX) && n < 20) begin
            step();
            n++;
        end
        check("mid_idx", 64'(round_idx), 64'(RST_IDX));
        rst_n = 1'b0;
        #1;
        check("mid_in_ready", 64'(in_ready), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_idx_clr", 64'(round_idx), 64'd0);
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_data", out_data, 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 64'(in_ready), 64'd1);
        issue(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
        wait_out(n);
        check("post_latency", 64'(n), 64'(LAT));
        check("post_data", out_data, 64'h85E813540F0AB405);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
